// File: rtl/tt04_adge28.sv
// rtl/tt04_adge28.sv - 4-bit accumulator CPU with serially loaded 16x5 program
// A program is written one word per enable edge, then executed at one instruction per clock.
module tt04_adge28 (
    input  logic       clk,
    input  logic       clear,
    input  logic       enable,
    input  logic [4:0] instruc,
    output logic [7:0] port_1
);

    typedef enum logic {
        MODE_LOAD = 1'b0,
        MODE_RUN  = 1'b1
    } mode_t;

    mode_t      r_mode;
    mode_t      w_mode_next;

    logic [3:0] r_wr_ptr;
    logic [3:0] r_pc;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic [3:0] r_out;
    logic       r_halted;
    logic       r_en_q;
    logic [4:0] r_prog [16];
    logic [3:0] r_ram  [4];

    logic       w_wr_stb;
    logic       w_exec;
    logic [4:0] w_instr;
    logic [3:0] w_a_next;
    logic [3:0] w_b_next;
    logic [3:0] w_out_next;
    logic       w_halt_set;
    logic       w_ram_we;

    assign w_wr_stb = enable & ~r_en_q & (r_mode == MODE_LOAD);
    assign w_exec   = (r_mode == MODE_RUN) & ~r_halted;
    assign w_instr  = r_prog[r_pc];

    always_ff @(posedge clk) begin
        if (clear) begin
            r_mode <= MODE_LOAD;
        end else begin
            r_mode <= w_mode_next;
        end
    end

    // Leaving LOAD happens only on the write that fills the last program slot.
    always_comb begin
        w_mode_next = r_mode;
        case (r_mode)
            MODE_LOAD: if (w_wr_stb && (r_wr_ptr == 4'hF)) w_mode_next = MODE_RUN;
            MODE_RUN:  w_mode_next = MODE_RUN;
            default:   w_mode_next = MODE_LOAD;
        endcase
    end

    always_comb begin
        w_a_next   = r_a;
        w_b_next   = r_b;
        w_out_next = r_out;
        w_halt_set = 1'b0;
        w_ram_we   = 1'b0;
        if (w_instr[4]) begin
            w_a_next = w_instr[3:0];
        end else begin
            case (w_instr[3:2])
                2'b00: begin
                    case (w_instr[1:0])
                        2'b01:   w_b_next   = r_a;
                        2'b10:   w_out_next = r_a;
                        2'b11:   w_halt_set = 1'b1;
                        default: ;
                    endcase
                end
                2'b01: begin
                    case (w_instr[1:0])
                        2'b00:   w_a_next = r_a + r_b;
                        2'b01:   w_a_next = r_a - r_b;
                        2'b10:   w_a_next = r_a & r_b;
                        default: w_a_next = r_a ^ r_b;
                    endcase
                end
                2'b10:   w_ram_we = 1'b1;
                default: w_a_next = r_ram[w_instr[1:0]];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_wr_ptr <= 4'h0;
            r_pc     <= 4'h0;
            r_a      <= 4'h0;
            r_b      <= 4'h0;
            r_out    <= 4'h0;
            r_halted <= 1'b0;
            r_en_q   <= 1'b0;
            for (int i = 0; i < 16; i++) r_prog[i] <= 5'b00000;
            for (int i = 0; i < 4; i++)  r_ram[i]  <= 4'h0;
        end else begin
            r_en_q <= enable;
            if (w_wr_stb) begin
                r_prog[r_wr_ptr] <= instruc;
                r_wr_ptr         <= r_wr_ptr + 4'd1;
                if (r_wr_ptr == 4'hF) r_pc <= 4'h0;
            end
            if (w_exec) begin
                r_a   <= w_a_next;
                r_b   <= w_b_next;
                r_out <= w_out_next;
                if (w_ram_we) r_ram[w_instr[1:0]] <= r_a;
                // HALT keeps pc on its own address so port_1 shows where it stopped.
                if (w_halt_set) r_halted <= 1'b1;
                else            r_pc     <= r_pc + 4'd1;
            end
        end
    end

    assign port_1 = {r_out, (r_mode == MODE_RUN) ? r_pc : r_wr_ptr};

endmodule

// File: tb/tb_tt04_adge28.sv
// tb/tb_tt04_adge28.sv - scoreboard bench for tt04_adge28
// Expected port_1 values are queued with the stimulus and popped as each cycle is sampled.
module tb_tt04_adge28;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       enable = 1'b0;
    logic [4:0] instruc = 5'b00000;
    logic [7:0] port_1;

    logic [7:0] exp_q [$];
    logic [7:0] exp_v;
    logic [4:0] pbuf [16];
    int         n_checks = 0;
    int         n_fail = 0;

    tt04_adge28 dut (
        .clk     (clk),
        .clear   (clear),
        .enable  (enable),
        .instruc (instruc),
        .port_1  (port_1)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic pulse(input logic [4:0] w);
        @(negedge clk);
        enable  = 1'b1;
        instruc = w;
        @(negedge clk);
        enable  = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear  = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        clear  = 1'b0;
    endtask

    task automatic nop_buf();
        for (int i = 0; i < 16; i++) pbuf[i] = 5'b00000;
    endtask

    task automatic load_buf();
        for (int i = 0; i < 16; i++) pulse(pbuf[i]);
    endtask

    task automatic test_reset();
        @(negedge clk);
        enable = 1'b1; instruc = 5'b10101;
        @(negedge clk);
        exp_q.push_back(8'h00);
        exp_v = exp_q.pop_front(); n_checks++;
        if (port_1 !== exp_v) begin
            n_fail++; $display("FAIL reset_state: got %h required %h", port_1, exp_v);
        end
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        clear = 1'b0; enable = 1'b0;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h01);
        @(negedge clk);
        exp_v = exp_q.pop_front(); n_checks++;
        if (port_1 !== exp_v) begin
            n_fail++; $display("FAIL reset_enable_ignored: got %h required %h", port_1, exp_v);
        end
        @(negedge clk);
        exp_v = exp_q.pop_front(); n_checks++;
        if (port_1 !== exp_v) begin
            n_fail++; $display("FAIL reset_hold: got %h required %h", port_1, exp_v);
        end
        pulse(5'b00000);
        exp_v = exp_q.pop_front(); n_checks++;
        if (port_1 !== exp_v) begin
            n_fail++; $display("FAIL reset_first_write: got %h required %h", port_1, exp_v);
        end
    endtask

    task automatic test_load_wrap();
        do_clear();
        for (int i = 0; i < 16; i++) begin
            pulse(5'b00000);
            exp_q.push_back({4'h0, 4'(i + 1)});
            exp_v = exp_q.pop_front(); n_checks++;
            if (port_1 !== exp_v) begin
                n_fail++; $display("FAIL load_ptr[%0d]: got %h required %h", i, port_1, exp_v);
            end
        end
        for (int c = 1; c <= 20; c++) exp_q.push_back({4'h0, 4'(c)});
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            exp_v = exp_q.pop_front(); n_checks++;
            if (port_1 !== exp_v) begin
                n_fail++; $display("FAIL run_pc[%0d]: got %h required %h", c, port_1, exp_v);
            end
        end
    endtask

    task automatic test_imm_out_halt();
        do_clear();
        nop_buf();
        pbuf[0] = 5'b10101; pbuf[1] = 5'b00010; pbuf[2] = 5'b00011;
        load_buf();
        exp_q.push_back(8'h01);
        for (int c = 0; c < 6; c++) exp_q.push_back(8'h52);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            // A run-mode enable edge must neither write nor disturb the halted state.
            if (c == 3) enable = 1'b1;
            if (c == 4) enable = 1'b0;
            exp_v = exp_q.pop_front(); n_checks++;
            if (port_1 !== exp_v) begin
                n_fail++; $display("FAIL imm_halt[%0d]: got %h required %h", c, port_1, exp_v);
            end
        end
    endtask

    task automatic test_alu();
        logic [4:0] a_init [6];
        logic [4:0] b_init [6];
        logic [4:0] ops    [6];
        logic [3:0] res    [6];
        // B gets the first immediate, A the second; last two cases hit the wrap boundaries.
        b_init = '{5'b10011, 5'b10011, 5'b10011, 5'b10011, 5'b11001, 5'b10001};
        a_init = '{5'b11001, 5'b11001, 5'b11001, 5'b11001, 5'b11001, 5'b10000};
        ops    = '{5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b00100, 5'b00101};
        res    = '{4'hC, 4'h6, 4'h1, 4'hA, 4'h2, 4'hF};
        for (int t = 0; t < 6; t++) begin
            do_clear();
            nop_buf();
            pbuf[0] = b_init[t]; pbuf[1] = 5'b00001; pbuf[2] = a_init[t];
            pbuf[3] = ops[t];    pbuf[4] = 5'b00010; pbuf[5] = 5'b00011;
            load_buf();
            exp_q.push_back({res[t], 4'h5});
            repeat (8) @(negedge clk);
            exp_v = exp_q.pop_front(); n_checks++;
            if (port_1 !== exp_v) begin
                n_fail++; $display("FAIL alu[%0d]: got %h required %h", t, port_1, exp_v);
            end
        end
    endtask

    task automatic test_ram();
        do_clear();
        nop_buf();
        pbuf[0] = 5'b10111; pbuf[1] = 5'b01000; pbuf[2] = 5'b10000; pbuf[3] = 5'b01100;
        pbuf[4] = 5'b00010; pbuf[5] = 5'b01101; pbuf[6] = 5'b00010; pbuf[7] = 5'b00011;
        load_buf();
        exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
        exp_q.push_back(8'h04); exp_q.push_back(8'h75); exp_q.push_back(8'h76);
        exp_q.push_back(8'h07); exp_q.push_back(8'h07); exp_q.push_back(8'h07);
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            exp_v = exp_q.pop_front(); n_checks++;
            if (port_1 !== exp_v) begin
                n_fail++; $display("FAIL ram[%0d]: got %h required %h", c, port_1, exp_v);
            end
        end
    endtask

    task automatic test_enable_edge();
        do_clear();
        @(negedge clk);
        enable = 1'b1; instruc = 5'b10001;
        exp_q.push_back(8'h01); exp_q.push_back(8'h01); exp_q.push_back(8'h01);
        exp_q.push_back(8'h01); exp_q.push_back(8'h02);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            exp_v = exp_q.pop_front(); n_checks++;
            if (port_1 !== exp_v) begin
                n_fail++; $display("FAIL enable_held[%0d]: got %h required %h", c, port_1, exp_v);
            end
        end
        enable = 1'b0;
        @(negedge clk);
        exp_v = exp_q.pop_front(); n_checks++;
        if (port_1 !== exp_v) begin
            n_fail++; $display("FAIL enable_release: got %h required %h", port_1, exp_v);
        end
        pulse(5'b00000);
        exp_v = exp_q.pop_front(); n_checks++;
        if (port_1 !== exp_v) begin
            n_fail++; $display("FAIL enable_second: got %h required %h", port_1, exp_v);
        end
    endtask

    task automatic test_clear_midrun();
        do_clear();
        nop_buf();
        pbuf[0] = 5'b10110; pbuf[1] = 5'b00010;
        load_buf();
        exp_q.push_back(8'h65);
        exp_q.push_back(8'h00);
        repeat (5) @(negedge clk);
        exp_v = exp_q.pop_front(); n_checks++;
        if (port_1 !== exp_v) begin
            n_fail++; $display("FAIL midrun_state: got %h required %h", port_1, exp_v);
        end
        do_clear();
        exp_v = exp_q.pop_front(); n_checks++;
        if (port_1 !== exp_v) begin
            n_fail++; $display("FAIL midrun_clear: got %h required %h", port_1, exp_v);
        end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (dut.r_prog[i] !== 5'b00000) begin
                n_fail++; $display("FAIL prog_nop[%0d]: got %b required 00000", i, dut.r_prog[i]);
            end
        end
        // OUT first after reload exposes whether A was cleared along with everything else.
        nop_buf();
        pbuf[0] = 5'b00010; pbuf[1] = 5'b00011;
        load_buf();
        exp_q.push_back(8'h01); exp_q.push_back(8'h01); exp_q.push_back(8'h01);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            exp_v = exp_q.pop_front(); n_checks++;
            if (port_1 !== exp_v) begin
                n_fail++; $display("FAIL midrun_a_cleared[%0d]: got %h required %h", c, port_1, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_wrap();
        test_imm_out_halt();
        test_alu();
        test_ram();
        test_enable_edge();
        test_clear_midrun();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
